tank_sprite_fetch: RTL and testbench
====================================

# tank_sprite_fetch

Per-scanline fetch controller for the tank sprites. During each horizontal blank it works out which tanks intersect the next display line. For each intersecting tank it reads that tank's 32-pixel sprite row from the shared single-port sprite ROM and writes the row into a per-tank line buffer, where the color mapper reads it for the following line. It is the only master on the sprite ROM and sequences all accesses to it.

## Interface
- SPRITE_H, 32, sprite height in lines; the sprite row index is 5 bits.
- WORDS_PER_ROW, 4, 32-bit ROM words per sprite row: 8 pixels at 4 bpp per word.
- ROM_LATENCY, 2, cycles from `rom_rd` to valid `rom_data`; legal range 1..4.
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous, active-low reset.
- line_start  in  1  single-cycle pulse at start of hblank; requests a fetch for line NextY.
- NextY  in  10  next display line, 0..479; sampled when line_start is accepted.
- TankOneY, TankTwoY  in  10 each  top edge of each tank sprite; sampled when line_start is accepted.
- TankOneDir, TankTwoDir  in  2 each  orientation (0=up, 1=right, 2=down, 3=left); selects the sprite image; sampled when line_start is accepted.
- rom_rd  out  1  ROM read strobe.
- rom_addr  out  10  {tank[0], dir[1:0], row[4:0], word[1:0]}.
- rom_data  in  32  ROM read data; valid ROM_LATENCY cycles after rom_rd.
- lb_we  out  1  line-buffer write enable.
- lb_sel  out  1  line-buffer select: 0 = tank one, 1 = tank two.
- lb_word  out  2  word index within the row.
- lb_data  out  32  data to write; equals the rom_data returned for that read.
- row_valid  out  2  bit0/bit1 set when tank one/tank two covers NextY.
- busy  out  1  high from acceptance until done.
- done  out  1  single-cycle pulse when all writes for the line are complete.
- overrun  out  1  single-cycle pulse when line_start arrives while busy.

## Operation
- States: IDLE, CHECK, ISSUE1, ISSUE2, DRAIN, DONE.
- IDLE: line_start=1 → latch NextY, both TankY values and both Dir values; go to CHECK; busy=1.
- CHECK (1 cycle):
  - hit_n = (NextY >= TanknY) && (NextY − TanknY < SPRITE_H), using unsigned 10-bit arithmetic; a tank below the line never hits, so there is no wrap-around.
  - row_n = (NextY − TanknY)[4:0].
  - row_valid is registered from hit at the end of CHECK.
  - Next state: ISSUE1 if hit1, else ISSUE2 if hit2, else DONE.
- ISSUE1 / ISSUE2: one rom_rd per cycle, word 0..3 in order; rom_addr = {tank, dir, row, word}.
  - After word 3 of ISSUE1, go to ISSUE2 if hit2, else DRAIN.
  - After word 3 of ISSUE2, go to DRAIN.
- Read tags: a shift register of depth ROM_LATENCY carries {valid, tank, word}. When a valid tag reaches the output stage: lb_we=1, lb_sel=tank, lb_word=word, lb_data=rom_data.
- DRAIN: wait until the tag pipe is empty, then go to DONE.
- DONE (1 cycle): done=1, busy=0 on the next cycle, return to IDLE.
- line_start while not in IDLE: ignored, overrun=1 for that cycle, latched values unchanged.
- Input changes after acceptance have no effect on the fetch in progress.

## Timing
- Reset (async assert, sync deassert handled upstream): state=IDLE, tag pipe cleared, and all outputs 0, including row_valid=2'b00. A reset during a fetch aborts it, and no further lb_we occurs after reset.
- Let N = number of hit tanks (0..2). Latency from line_start (cycle 0) to done:
  - N=0: CHECK at cycle 1, done at cycle 2.
  - N≥1: rom_rd high on cycles 2 .. 1+4N, back-to-back with no gaps; last lb_we at cycle 1+4N+ROM_LATENCY; done at cycle 2+4N+ROM_LATENCY.
- Worst case with ROM_LATENCY=2: done at cycle 12. This is well inside the 160-cycle VGA hblank at the pixel clock.
- At most one rom_rd per cycle and 8 reads per line.
- lb_we pulses are in issue order, one cycle each.
- row_valid is stable from the cycle after CHECK until the next accepted CHECK.

## Test plan
- Reset mid-fetch:
  - Stimulus: TankOneY=100, NextY=110, line_start, then Reset_n=0 in the cycle after the first rom_rd.
  - Required: lb_we never asserts; busy=0, row_valid=0 during reset; the next line_start performs a normal fetch.
- Single tank:
  - Stimulus: TankOneY=100, TankTwoY=300, TankOneDir=2, NextY=110, line_start.
  - Required: row_valid=01; rom_addr = 0_10_01010_00 .. _11 on cycles 2..5; lb_we on cycles 4..7 with lb_sel=0; done at cycle 8.
- Both tanks, boundary rows:
  - Stimulus: TankOneY=200, TankTwoY=169, NextY=200.
  - Required: row_valid=11; tank one row 0, tank two row 31; 8 consecutive reads; done at cycle 12.
- Miss boundaries:
  - Stimulus: TankOneY=168 with NextY=200 (difference 32), and TankTwoY=201 (above-line check).
  - Required: row_valid=00; no rom_rd; done at cycle 2.
- Overrun:
  - Stimulus: a second line_start at cycle 4 of a 2-tank fetch.
  - Required: overrun pulses at cycle 4; fetch unchanged; done still at cycle 12; no extra reads.
- Latency parameter:
  - Stimulus: ROM_LATENCY=4, single-hit case above.
  - Required: lb_data equals the ROM model data for every word; done at cycle 10.

Source files
------------

// File: rtl/tank_sprite_fetch_if.sv
// ---------------------------------------------------------------------------
// tank_sprite_fetch_if
//
// Groups the signals that connect the tank sprite fetch controller to
// the line timing logic, the sprite ROM and the per-tank line buffers.
//
//   line_start   line timing -> fetch   start-of-hblank pulse
//   NextY        line timing -> fetch   next display line
//   TankOneY/Dir game logic  -> fetch   tank one top edge / orientation
//   TankTwoY/Dir game logic  -> fetch   tank two top edge / orientation
//   rom_rd       fetch -> ROM           read strobe
//   rom_addr     fetch -> ROM           {tank, dir, row, word}
//   rom_data     ROM -> fetch           read data, fixed latency
//   lb_we/sel/word/data  fetch -> line buffers  one sprite word write
//   row_valid    fetch -> color mapper  which tanks cover the next line
//   busy/done/overrun    fetch -> status
//
// The fetch controller uses the master modport; the surrounding system
// (or a testbench) uses the slave modport.
// ---------------------------------------------------------------------------
interface tank_sprite_fetch_if;
  logic        line_start;
  logic [9:0]  NextY;
  logic [9:0]  TankOneY;
  logic [9:0]  TankTwoY;
  logic [1:0]  TankOneDir;
  logic [1:0]  TankTwoDir;

  logic        rom_rd;
  logic [9:0]  rom_addr;
  logic [31:0] rom_data;

  logic        lb_we;
  logic        lb_sel;
  logic [1:0]  lb_word;
  logic [31:0] lb_data;

  logic [1:0]  row_valid;
  logic        busy;
  logic        done;
  logic        overrun;

  modport master (
    input  line_start, NextY, TankOneY, TankTwoY, TankOneDir, TankTwoDir,
    input  rom_data,
    output rom_rd, rom_addr,
    output lb_we, lb_sel, lb_word, lb_data,
    output row_valid, busy, done, overrun
  );

  modport slave (
    output line_start, NextY, TankOneY, TankTwoY, TankOneDir, TankTwoDir,
    output rom_data,
    input  rom_rd, rom_addr,
    input  lb_we, lb_sel, lb_word, lb_data,
    input  row_valid, busy, done, overrun
  );
endinterface

// File: rtl/tank_sprite_fetch.sv
// ---------------------------------------------------------------------------
// tank_sprite_fetch
//
// Per-scanline fetch controller for the two tank sprites. On each
// line_start it latches the next line number and both tank positions and
// orientations, decides which tanks cover that line, then reads the
// matching 32-pixel sprite row (four 32-bit words) of each covering tank
// from the single-port sprite ROM and writes it into that tank's line
// buffer.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    tank_sprite_fetch_if.master (see the interface for signals)
//
// Parameters:
//   SPRITE_H       sprite height in lines (row index is 5 bits)
//   WORDS_PER_ROW  ROM words per sprite row (word index is 2 bits)
//   ROM_LATENCY    cycles from rom_rd to valid rom_data, 1..4
// ---------------------------------------------------------------------------
module tank_sprite_fetch #(
  parameter int SPRITE_H      = 32,
  parameter int WORDS_PER_ROW = 4,
  parameter int ROM_LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tank_sprite_fetch_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ISSUE1,
    ISSUE2,
    DRAIN,
    DONE
  } state_t;

  localparam logic [1:0] LastWord = 2'(WORDS_PER_ROW - 1);

  // Every tag stage except the output stage; if none of these hold a read
  // then the pipe is empty after the next edge.
  localparam logic [ROM_LATENCY-1:0] EarlyMask = {ROM_LATENCY{1'b1}} >> 1;

  state_t      state_q;
  logic [9:0]  nextY_q;
  logic [9:0]  tankOneY_q;
  logic [9:0]  tankTwoY_q;
  logic [1:0]  dirOne_q;
  logic [1:0]  dirTwo_q;
  logic [1:0]  word_q;
  logic [1:0]  rowValid_q;

  // Read tags travel alongside the ROM latency so that each returned word
  // knows which tank and word slot it belongs to.
  logic [ROM_LATENCY-1:0] tagValid_q;
  logic                   tagTank_q [ROM_LATENCY];
  logic [1:0]             tagWord_q [ROM_LATENCY];

  logic [9:0]  diffOne;
  logic [9:0]  diffTwo;
  logic        hitOne;
  logic        hitTwo;
  logic [1:0]  rowValid_d;
  logic        issue;
  logic        issueTank;
  logic [1:0]  issueDir;
  logic [4:0]  issueRow;
  logic        tagPending;

  // Coverage test on the latched values. The >= guard rules out tanks
  // that start below the line, so the 10-bit subtraction never wraps into
  // a false hit.
  assign diffOne    = nextY_q - tankOneY_q;
  assign diffTwo    = nextY_q - tankTwoY_q;
  assign hitOne     = (nextY_q >= tankOneY_q) && (diffOne < 10'(SPRITE_H));
  assign hitTwo     = (nextY_q >= tankTwoY_q) && (diffTwo < 10'(SPRITE_H));
  assign rowValid_d = {hitTwo, hitOne};

  // Issue-side address fields. The latched values stay stable for the
  // whole fetch, so the row can be derived directly from them.
  assign issue     = (state_q == ISSUE1) || (state_q == ISSUE2);
  assign issueTank = (state_q == ISSUE2);
  assign issueDir  = issueTank ? dirTwo_q : dirOne_q;
  assign issueRow  = issueTank ? diffTwo[4:0] : diffOne[4:0];

  assign tagPending = |(tagValid_q & EarlyMask);

  // Control FSM plus input latches and the read-tag shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      nextY_q    <= '0;
      tankOneY_q <= '0;
      tankTwoY_q <= '0;
      dirOne_q   <= '0;
      dirTwo_q   <= '0;
      word_q     <= '0;
      rowValid_q <= '0;
      tagValid_q <= '0;
      for (int i = 0; i < ROM_LATENCY; i++) begin
        tagTank_q[i] <= 1'b0;
        tagWord_q[i] <= '0;
      end
    end else begin
      for (int i = ROM_LATENCY - 1; i > 0; i--) begin
        tagValid_q[i] <= tagValid_q[i-1];
        tagTank_q[i]  <= tagTank_q[i-1];
        tagWord_q[i]  <= tagWord_q[i-1];
      end
      tagValid_q[0] <= issue;
      tagTank_q[0]  <= issueTank;
      tagWord_q[0]  <= word_q;

      case (state_q)
        IDLE: begin
          if (bus.line_start) begin
            nextY_q    <= bus.NextY;
            tankOneY_q <= bus.TankOneY;
            tankTwoY_q <= bus.TankTwoY;
            dirOne_q   <= bus.TankOneDir;
            dirTwo_q   <= bus.TankTwoDir;
            state_q    <= CHECK;
          end
        end
        CHECK: begin
          rowValid_q <= rowValid_d;
          word_q     <= '0;
          if (hitOne)      state_q <= ISSUE1;
          else if (hitTwo) state_q <= ISSUE2;
          else             state_q <= DONE;
        end
        ISSUE1: begin
          // The word counter wraps to 0 on the last word, ready for ISSUE2.
          word_q <= word_q + 2'd1;
          if (word_q == LastWord) begin
            state_q <= rowValid_q[1] ? ISSUE2 : DRAIN;
          end
        end
        ISSUE2: begin
          word_q <= word_q + 2'd1;
          if (word_q == LastWord) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (!tagPending) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // ROM side: address forced to zero whenever no read is issued.
  assign bus.rom_rd   = issue;
  assign bus.rom_addr = issue ? {issueTank, issueDir, issueRow, word_q} : '0;

  // Line-buffer side: the output tag stage lines up with returning data.
  assign bus.lb_we   = tagValid_q[ROM_LATENCY-1];
  assign bus.lb_sel  = bus.lb_we & tagTank_q[ROM_LATENCY-1];
  assign bus.lb_word = bus.lb_we ? tagWord_q[ROM_LATENCY-1] : 2'd0;
  assign bus.lb_data = bus.lb_we ? bus.rom_data : 32'd0;

  assign bus.row_valid = rowValid_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.overrun   = bus.line_start && (state_q != IDLE);

endmodule

// File: tb/tb_tank_sprite_fetch.sv
// ---------------------------------------------------------------------------
// tb_tank_sprite_fetch
//
// Drives two fetch controllers side by side with identical stimulus, one
// with ROM_LATENCY=2 and one with ROM_LATENCY=4, each with its own ROM
// model. Expected line-buffer writes are queued when a line is started and
// compared as each controller writes them.
// ---------------------------------------------------------------------------
module tb_tank_sprite_fetch;

  typedef struct packed {
    logic        sel;
    logic [1:0]  word;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  logic        lineStart;
  logic [9:0]  nextY;
  logic [9:0]  tankOneY;
  logic [9:0]  tankTwoY;
  logic [1:0]  dirOne;
  logic [1:0]  dirTwo;

  int total = 0;
  int bad   = 0;

  wr_t qA[$];
  wr_t qB[$];

  tank_sprite_fetch_if busA ();
  tank_sprite_fetch_if busB ();

  // ROM content: unique per address so a wrong address shows up as wrong data.
  function automatic logic [31:0] romWord(input logic [9:0] a);
    return {a, ~a, 2'b01, a};
  endfunction

  logic [9:0] pipeA [2];
  logic [9:0] pipeB [4];

  always @(posedge clk) begin
    pipeA[0] <= busA.rom_addr;
    pipeA[1] <= pipeA[0];
    pipeB[0] <= busB.rom_addr;
    for (int i = 1; i < 4; i++) pipeB[i] <= pipeB[i-1];
  end

  assign busA.line_start = lineStart;
  assign busA.NextY      = nextY;
  assign busA.TankOneY   = tankOneY;
  assign busA.TankTwoY   = tankTwoY;
  assign busA.TankOneDir = dirOne;
  assign busA.TankTwoDir = dirTwo;
  assign busA.rom_data   = romWord(pipeA[1]);

  assign busB.line_start = lineStart;
  assign busB.NextY      = nextY;
  assign busB.TankOneY   = tankOneY;
  assign busB.TankTwoY   = tankTwoY;
  assign busB.TankOneDir = dirOne;
  assign busB.TankTwoDir = dirTwo;
  assign busB.rom_data   = romWord(pipeB[3]);

  tank_sprite_fetch #(.SPRITE_H(32), .WORDS_PER_ROW(4), .ROM_LATENCY(2)) dutA (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busA)
  );

  tank_sprite_fetch #(.SPRITE_H(32), .WORDS_PER_ROW(4), .ROM_LATENCY(4)) dutB (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busB)
  );

  logic [1:0] rdV, weV, doneV, busyV, ovV;
  assign rdV   = {busB.rom_rd,  busA.rom_rd};
  assign weV   = {busB.lb_we,   busA.lb_we};
  assign doneV = {busB.done,    busA.done};
  assign busyV = {busB.busy,    busA.busy};
  assign ovV   = {busB.overrun, busA.overrun};

  int lat [2] = '{2, 4};

  // Per-line measurements, index 0 = latency-2 unit, 1 = latency-4 unit.
  int         rdCnt [2];
  int         firstRd [2];
  int         lastRd [2];
  int         weCnt [2];
  int         firstWe [2];
  int         lastWe [2];
  int         doneCyc [2];
  int         doneCnt [2];
  int         ovCnt [2];
  int         ovCyc [2];
  logic       busyAt1 [2];
  logic       busyAfter [2];
  logic [1:0] rvEnd [2];
  logic [9:0] addrLog [24];
  int         expN;
  logic [1:0] expRv;

  // Scoreboard, latency-2 unit.
  always @(negedge clk) begin
    wr_t e;
    wr_t g;
    #1;
    if (busA.lb_we === 1'b1) begin
      g = {busA.lb_sel, busA.lb_word, busA.lb_data};
      total++;
      if (qA.size() == 0) begin
        bad++;
        $display("[TB] FAIL lbwrite dut0 unexpected got=%h exp=none", g);
      end else begin
        e = qA.pop_front();
        if (g !== e) begin
          bad++;
          $display("[TB] FAIL lbwrite dut0 got=%h exp=%h", g, e);
        end
      end
    end
  end

  // Scoreboard, latency-4 unit.
  always @(negedge clk) begin
    wr_t e;
    wr_t g;
    #1;
    if (busB.lb_we === 1'b1) begin
      g = {busB.lb_sel, busB.lb_word, busB.lb_data};
      total++;
      if (qB.size() == 0) begin
        bad++;
        $display("[TB] FAIL lbwrite dut1 unexpected got=%h exp=none", g);
      end else begin
        e = qB.pop_front();
        if (g !== e) begin
          bad++;
          $display("[TB] FAIL lbwrite dut1 got=%h exp=%h", g, e);
        end
      end
    end
  end

  // Starts one line, queues the expected writes from the bench's own
  // coverage model and records 24 cycles of activity. A second line_start
  // with scrambled inputs is injected at cycle ovAt (disabled if < 1).
  task automatic runLine(input logic [9:0] ny, input logic [9:0] y1,
                         input logic [9:0] y2, input logic [1:0] d1,
                         input logic [1:0] d2, input int ovAt);
    int  dy1, dy2;
    logic h1, h2;
    wr_t w;
    dy1 = int'(ny) - int'(y1);
    dy2 = int'(ny) - int'(y2);
    h1  = (dy1 >= 0) && (dy1 < 32);
    h2  = (dy2 >= 0) && (dy2 < 32);
    expN  = int'(h1) + int'(h2);
    expRv = {h2, h1};
    for (int k = 0; k < 4; k++) begin
      if (h1) begin
        w = {1'b0, 2'(k), romWord({1'b0, d1, 5'(dy1), 2'(k)})};
        qA.push_back(w);
        qB.push_back(w);
      end
    end
    for (int k = 0; k < 4; k++) begin
      if (h2) begin
        w = {1'b1, 2'(k), romWord({1'b1, d2, 5'(dy2), 2'(k)})};
        qA.push_back(w);
        qB.push_back(w);
      end
    end
    for (int d = 0; d < 2; d++) begin
      rdCnt[d] = 0; firstRd[d] = -1; lastRd[d] = -1;
      weCnt[d] = 0; firstWe[d] = -1; lastWe[d] = -1;
      doneCyc[d] = -1; doneCnt[d] = 0; ovCnt[d] = 0; ovCyc[d] = -1;
      busyAt1[d] = 1'b0; busyAfter[d] = 1'b1;
    end
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (c == 0) begin
        nextY = ny; tankOneY = y1; tankTwoY = y2; dirOne = d1; dirTwo = d2;
        lineStart = 1'b1;
      end else if (c == ovAt) begin
        nextY = 10'd0; tankOneY = 10'd0; tankTwoY = 10'd0;
        dirOne = ~d1; dirTwo = ~d2;
        lineStart = 1'b1;
      end else begin
        lineStart = 1'b0;
      end
      #1;
      addrLog[c] = busA.rom_addr;
      for (int d = 0; d < 2; d++) begin
        if (rdV[d]) begin
          rdCnt[d]++;
          if (firstRd[d] < 0) firstRd[d] = c;
          lastRd[d] = c;
        end
        if (weV[d]) begin
          weCnt[d]++;
          if (firstWe[d] < 0) firstWe[d] = c;
          lastWe[d] = c;
        end
        if (doneCyc[d] >= 0 && c == doneCyc[d] + 1) busyAfter[d] = busyV[d];
        if (doneV[d]) begin
          doneCnt[d]++;
          if (doneCyc[d] < 0) doneCyc[d] = c;
        end
        if (ovV[d]) begin
          ovCnt[d]++;
          if (ovCyc[d] < 0) ovCyc[d] = c;
        end
        if (c == 1) busyAt1[d] = busyV[d];
      end
    end
    rvEnd[0] = busA.row_valid;
    rvEnd[1] = busB.row_valid;
  endtask

  task automatic test_reset();
    lineStart = 1'b0;
    nextY = '0; tankOneY = '0; tankTwoY = '0; dirOne = '0; dirTwo = '0;
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if ({busyV, rdV, weV, doneV, ovV} !== 10'd0) begin
      bad++;
      $display("[TB] FAIL reset.status got=%b exp=%b", {busyV, rdV, weV, doneV, ovV}, 10'd0);
    end
    total++;
    if ({busA.row_valid, busB.row_valid} !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL reset.row_valid got=%b exp=0000", {busA.row_valid, busB.row_valid});
    end
    total++;
    if ({busA.rom_addr, busA.lb_data, busB.rom_addr, busB.lb_data} !== 84'd0) begin
      bad++;
      $display("[TB] FAIL reset.buses got=%h exp=0", {busA.rom_addr, busA.lb_data, busB.rom_addr, busB.lb_data});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    runLine(10'd110, 10'd100, 10'd300, 2'd2, 2'd0, -1);
    total++;
    if (addrLog[2] !== 10'b0_10_01010_00) begin
      bad++;
      $display("[TB] FAIL single.addr2 got=%b exp=%b", addrLog[2], 10'b0_10_01010_00);
    end
    total++;
    if (addrLog[5] !== 10'b0_10_01010_11) begin
      bad++;
      $display("[TB] FAIL single.addr5 got=%b exp=%b", addrLog[5], 10'b0_10_01010_11);
    end
    for (int d = 0; d < 2; d++) begin
      total++;
      if (rvEnd[d] !== 2'b01) begin
        bad++;
        $display("[TB] FAIL single.row_valid dut%0d got=%b exp=01", d, rvEnd[d]);
      end
      total++;
      if ({rdCnt[d], firstRd[d], lastRd[d]} !== {32'd4, 32'd2, 32'd5}) begin
        bad++;
        $display("[TB] FAIL single.reads dut%0d got=%0d/%0d..%0d exp=4/2..5", d, rdCnt[d], firstRd[d], lastRd[d]);
      end
      total++;
      if ({weCnt[d], firstWe[d], lastWe[d]} !== {32'd4, 32'(2 + lat[d]), 32'(5 + lat[d])}) begin
        bad++;
        $display("[TB] FAIL single.writes dut%0d got=%0d/%0d..%0d exp=4/%0d..%0d", d, weCnt[d], firstWe[d], lastWe[d], 2 + lat[d], 5 + lat[d]);
      end
      total++;
      if ({doneCyc[d], doneCnt[d]} !== {32'(6 + lat[d]), 32'd1}) begin
        bad++;
        $display("[TB] FAIL single.done dut%0d got=cyc%0d x%0d exp=cyc%0d x1", d, doneCyc[d], doneCnt[d], 6 + lat[d]);
      end
      total++;
      if ({busyAt1[d], busyAfter[d]} !== 2'b10) begin
        bad++;
        $display("[TB] FAIL single.busy dut%0d got=%b%b exp=10", d, busyAt1[d], busyAfter[d]);
      end
    end
  endtask

  task automatic test_reset_mid_fetch();
    int weSeen;
    weSeen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 0) begin
        nextY = 10'd110; tankOneY = 10'd100; tankTwoY = 10'd300;
        dirOne = 2'd1; dirTwo = 2'd0;
        lineStart = 1'b1;
      end else begin
        lineStart = 1'b0;
      end
      if (c == 3) rst_n = 1'b0;
      if (c == 6) rst_n = 1'b1;
      #1;
      if (weV != 2'b00) weSeen++;
      if (c == 2) begin
        total++;
        if ({busA.row_valid, busB.row_valid} !== 4'b0101) begin
          bad++;
          $display("[TB] FAIL rstmid.row_valid_before got=%b exp=0101", {busA.row_valid, busB.row_valid});
        end
      end
      if (c == 4) begin
        total++;
        if ({busyV, rdV, busA.row_valid, busB.row_valid} !== 8'd0) begin
          bad++;
          $display("[TB] FAIL rstmid.during got=%b exp=0", {busyV, rdV, busA.row_valid, busB.row_valid});
        end
      end
    end
    total++;
    if (weSeen != 0) begin
      bad++;
      $display("[TB] FAIL rstmid.lb_we got=%0d exp=0", weSeen);
    end
  endtask

  task automatic test_both();
    runLine(10'd200, 10'd200, 10'd169, 2'd1, 2'd3, -1);
    total++;
    if (addrLog[2] !== 10'b0_01_00000_00) begin
      bad++;
      $display("[TB] FAIL both.addr_t1 got=%b exp=%b", addrLog[2], 10'b0_01_00000_00);
    end
    total++;
    if (addrLog[6] !== 10'b1_11_11111_00) begin
      bad++;
      $display("[TB] FAIL both.addr_t2 got=%b exp=%b", addrLog[6], 10'b1_11_11111_00);
    end
    for (int d = 0; d < 2; d++) begin
      total++;
      if (rvEnd[d] !== 2'b11) begin
        bad++;
        $display("[TB] FAIL both.row_valid dut%0d got=%b exp=11", d, rvEnd[d]);
      end
      total++;
      if ({rdCnt[d], firstRd[d], lastRd[d]} !== {32'd8, 32'd2, 32'd9}) begin
        bad++;
        $display("[TB] FAIL both.reads dut%0d got=%0d/%0d..%0d exp=8/2..9", d, rdCnt[d], firstRd[d], lastRd[d]);
      end
      total++;
      if ({doneCyc[d], lastWe[d]} !== {32'(10 + lat[d]), 32'(9 + lat[d])}) begin
        bad++;
        $display("[TB] FAIL both.timing dut%0d got=done%0d lastwe%0d exp=done%0d lastwe%0d", d, doneCyc[d], lastWe[d], 10 + lat[d], 9 + lat[d]);
      end
    end
  endtask

  task automatic test_miss();
    runLine(10'd200, 10'd168, 10'd201, 2'd0, 2'd2, -1);
    for (int d = 0; d < 2; d++) begin
      total++;
      if (rvEnd[d] !== 2'b00) begin
        bad++;
        $display("[TB] FAIL miss.row_valid dut%0d got=%b exp=00", d, rvEnd[d]);
      end
      total++;
      if ({rdCnt[d], weCnt[d], doneCyc[d]} !== {32'd0, 32'd0, 32'd2}) begin
        bad++;
        $display("[TB] FAIL miss.activity dut%0d got=rd%0d we%0d done%0d exp=rd0 we0 done2", d, rdCnt[d], weCnt[d], doneCyc[d]);
      end
    end
  endtask

  task automatic test_overrun();
    runLine(10'd200, 10'd200, 10'd169, 2'd2, 2'd1, 4);
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({ovCnt[d], ovCyc[d]} !== {32'd1, 32'd4}) begin
        bad++;
        $display("[TB] FAIL overrun.pulse dut%0d got=x%0d cyc%0d exp=x1 cyc4", d, ovCnt[d], ovCyc[d]);
      end
      total++;
      if ({rdCnt[d], doneCyc[d], doneCnt[d]} !== {32'd8, 32'(10 + lat[d]), 32'd1}) begin
        bad++;
        $display("[TB] FAIL overrun.fetch dut%0d got=rd%0d done%0d x%0d exp=rd8 done%0d x1", d, rdCnt[d], doneCyc[d], doneCnt[d], 10 + lat[d]);
      end
      total++;
      if (rvEnd[d] !== 2'b11) begin
        bad++;
        $display("[TB] FAIL overrun.row_valid dut%0d got=%b exp=11", d, rvEnd[d]);
      end
    end
  endtask

  task automatic test_random();
    int ny, o1, o2, y1, y2, expDone;
    for (int it = 0; it < 6; it++) begin
      ny = int'($urandom_range(0, 479));
      o1 = int'($urandom_range(0, 40)) - 4;
      o2 = int'($urandom_range(0, 40)) - 4;
      y1 = (ny - o1 < 0) ? 0 : ny - o1;
      y2 = (ny - o2 < 0) ? 0 : ny - o2;
      runLine(10'(ny), 10'(y1), 10'(y2), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), -1);
      for (int d = 0; d < 2; d++) begin
        expDone = (expN == 0) ? 2 : 2 + 4 * expN + lat[d];
        total++;
        if ({rvEnd[d], rdCnt[d], doneCyc[d]} !== {expRv, 32'(4 * expN), 32'(expDone)}) begin
          bad++;
          $display("[TB] FAIL random%0d dut%0d got=rv%b rd%0d done%0d exp=rv%b rd%0d done%0d", it, d, rvEnd[d], rdCnt[d], doneCyc[d], expRv, 4 * expN, expDone);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_reset_mid_fetch();
    test_both();
    test_miss();
    test_overrun();
    test_random();
    repeat (4) @(negedge clk);
    total++;
    if (qA.size() != 0 || qB.size() != 0) begin
      bad++;
      $display("[TB] FAIL scoreboard.leftover got=%0d/%0d exp=0/0", qA.size(), qB.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
